// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage pipeline.
// Holds one instruction in the EX/MEM register. It performs at most one
// data-memory access over a req/ack handshake. It drives a registered
// write-back bundle and owns the architectural CCR flag register.
//
// Handshakes:
// - Upstream: valid/ready. A transfer occurs on a rising edge where
//   ex_valid && ex_ready. ex_ready depends only on state and flush, never
//   on dmem_ack.
// - Memory side: req/ack. dmem_req stays high with addr/we/wdata stable
//   from the cycle after accept until the edge where dmem_ack is sampled
//   high. An ack seen while dmem_req is low is ignored.
module mem_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [2:0]        ex_ccr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [2:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_ccr_we,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write,
  output logic [2:0]        ccr,
  output logic              fwd_valid,
  output logic [2:0]        fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_ALU_HOLD = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  // EX/MEM register contents
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [2:0]        ccr_in_q, ccr_in_d;
  logic [2:0]        rd_q, rd_d;
  logic              is_load_q, is_load_d;
  logic              is_store_q, is_store_d;
  logic              reg_write_q, reg_write_d;
  logic              ccr_we_q, ccr_we_d;
  logic              squashed_q, squashed_d;

  // Write-back bundle and architectural flags
  logic              wb_valid_q, wb_valid_d;
  logic [2:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [2:0]        ccr_q, ccr_d;

  logic accept;
  logic mem_op;
  logic complete;
  logic retire;

  assign mem_op = ex_mem_read || ex_mem_write;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, accept and completion decode
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    ex_ready = (state_q != ST_MEM_WAIT) && !flush;
    accept   = ex_valid && ex_ready;
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = mem_op ? ST_MEM_WAIT : ST_ALU_HOLD;
      end
      ST_ALU_HOLD: begin
        // The held ALU op always leaves on this edge; a flush only
        // suppresses its write-back, which happens through retire.
        complete = 1'b1;
        if (accept) state_d = mem_op ? ST_MEM_WAIT : ST_ALU_HOLD;
        else        state_d = ST_EMPTY;
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          complete = 1'b1;
          state_d  = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush arriving on the ack cycle squashes the access like an
    // earlier one.
    retire = complete && !squashed_q && !flush;
  end

  // Output decode from state and held instruction
  always_comb begin
    dmem_req   = (state_q == ST_MEM_WAIT);
    dmem_we    = (state_q == ST_MEM_WAIT) && is_store_q;
    dmem_addr  = alu_q[ADDR_W-1:0];
    dmem_wdata = sdata_q;
    fwd_valid  = (state_q == ST_ALU_HOLD) && reg_write_q && !squashed_q;
    fwd_rd     = rd_q;
    fwd_data   = alu_q;
  end

  // EX/MEM register load on accept; squash marking while an access is out
  always_comb begin
    alu_d       = alu_q;
    sdata_d     = sdata_q;
    ccr_in_d    = ccr_in_q;
    rd_d        = rd_q;
    is_load_d   = is_load_q;
    is_store_d  = is_store_q;
    reg_write_d = reg_write_q;
    ccr_we_d    = ccr_we_q;
    squashed_d  = squashed_q;
    if (accept) begin
      alu_d       = ex_alu_result;
      sdata_d     = ex_store_data;
      ccr_in_d    = ex_ccr;
      rd_d        = ex_rd;
      // When both read and write are set, the write wins: it is a store
      // and never writes a register.
      is_store_d  = ex_mem_write;
      is_load_d   = ex_mem_read && !ex_mem_write;
      reg_write_d = ex_reg_write && !ex_mem_write;
      ccr_we_d    = ex_ccr_we;
      squashed_d  = 1'b0;
    end else if ((state_q == ST_MEM_WAIT) && flush) begin
      squashed_d  = 1'b1;
    end
  end

  // EX/MEM register flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q       <= '0;
      sdata_q     <= '0;
      ccr_in_q    <= '0;
      rd_q        <= '0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      reg_write_q <= 1'b0;
      ccr_we_q    <= 1'b0;
      squashed_q  <= 1'b0;
    end else begin
      alu_q       <= alu_d;
      sdata_q     <= sdata_d;
      ccr_in_q    <= ccr_in_d;
      rd_q        <= rd_d;
      is_load_q   <= is_load_d;
      is_store_q  <= is_store_d;
      reg_write_q <= reg_write_d;
      ccr_we_q    <= ccr_we_d;
      squashed_q  <= squashed_d;
    end
  end

  // Write-back bundle and CCR update on a non-squashed completion
  always_comb begin
    wb_valid_d     = retire;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_reg_write_d = wb_reg_write_q;
    ccr_d          = ccr_q;
    if (retire) begin
      wb_rd_d        = rd_q;
      wb_data_d      = is_load_q ? dmem_rdata : alu_q;
      wb_reg_write_d = reg_write_q;
      if (ccr_we_q) ccr_d = ccr_in_q;
    end
  end

  // Write-back and CCR flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_reg_write_q <= 1'b0;
      ccr_q          <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_reg_write_q <= wb_reg_write_d;
      ccr_q          <= ccr_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_reg_write = wb_reg_write_q;
  assign ccr          = ccr_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// transaction-level model of the stage's behaviour.
module tb_mem_stage;
  localparam int DW = 16;
  localparam int AW = 16;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ex_valid, ex_ready;
  logic [DW-1:0] ex_alu_result, ex_store_data;
  logic [2:0]    ex_ccr, ex_rd;
  logic          ex_mem_read, ex_mem_write, ex_reg_write, ex_ccr_we, flush;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          wb_valid, wb_reg_write, fwd_valid;
  logic [2:0]    wb_rd, ccr, fwd_rd;
  logic [DW-1:0] wb_data, fwd_data;

  mem_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_ccr(ex_ccr),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_ccr_we(ex_ccr_we),
    .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .ccr(ccr),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  // Scoreboard: expected write-back packets {rd, data, reg_write}
  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  // Transaction-level model: the one instruction in the stage
  logic          m_pend, m_mem, m_load, m_store, m_rw, m_cw, m_sq;
  logic [2:0]    m_rd, m_ccrin, m_ccr;
  logic [DW-1:0] m_alu, m_sd;
  int            m_delay;
  bit            auto_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_mem = 1'b0; m_load = 1'b0; m_store = 1'b0;
    m_rw = 1'b0; m_cw = 1'b0; m_sq = 1'b0;
    m_rd = '0; m_ccrin = '0; m_ccr = '0; m_alu = '0; m_sd = '0;
    m_delay = 0;
    exp_q.delete();
  endtask

  // Effect of one rising edge on the model, using the inputs driven now
  task automatic model_edge();
    bit rdy, comp;
    logic [DW-1:0] wdat;
    rdy  = !(m_pend && m_mem) && !flush;
    comp = 1'b0;
    if (m_pend) begin
      if (!m_mem) begin
        comp   = !flush;
        m_pend = 1'b0;
      end else begin
        if (flush) m_sq = 1'b1;
        if (dmem_ack) begin
          comp   = !m_sq;
          m_pend = 1'b0;
        end else if (m_delay > 0) begin
          m_delay--;
        end
      end
    end
    if (comp) begin
      wdat = m_load ? dmem_rdata : m_alu;
      exp_q.push_back({m_rd, wdat, (m_store ? 1'b0 : m_rw)});
      if (m_cw) m_ccr = m_ccrin;
    end
    if (ex_valid && rdy) begin
      m_pend  = 1'b1;
      m_mem   = ex_mem_read || ex_mem_write;
      m_store = ex_mem_write;
      m_load  = ex_mem_read && !ex_mem_write;
      m_rw    = ex_reg_write;
      m_cw    = ex_ccr_we;
      m_rd    = ex_rd;
      m_alu   = ex_alu_result;
      m_sd    = ex_store_data;
      m_ccrin = ex_ccr;
      m_sq    = 1'b0;
      m_delay = $urandom_range(0, 3);
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic check_outputs();
    logic exp_req, exp_fwd;
    logic [19:0] pkt;
    exp_req = m_pend && m_mem;
    chk("ex_ready", ex_ready, !exp_req && !flush);
    chk("dmem_req", dmem_req, exp_req);
    if (exp_req) begin
      chk("dmem_addr", dmem_addr, m_alu);
      chk("dmem_we", dmem_we, m_store);
      chk("dmem_wdata", dmem_wdata, m_sd);
    end
    chk("wb_valid", wb_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      pkt = exp_q.pop_front();
      chk("wb_rd", wb_rd, pkt[19:17]);
      chk("wb_data", wb_data, pkt[16:1]);
      chk("wb_reg_write", wb_reg_write, pkt[0]);
    end
    chk("ccr", ccr, m_ccr);
    exp_fwd = m_pend && !m_mem && m_rw;
    chk("fwd_valid", fwd_valid, exp_fwd);
    if (exp_fwd) begin
      chk("fwd_rd", fwd_rd, m_rd);
      chk("fwd_data", fwd_data, m_alu);
    end
  endtask

  // Memory responder for the random phase
  task automatic respond();
    if (!auto_ack) return;
    dmem_rdata = DW'($urandom);
    if (m_pend && m_mem) dmem_ack = (m_delay == 0);
    else                 dmem_ack = ($urandom_range(0, 7) == 0);
  endtask

  // One clock cycle: inputs already driven at posedge+1
  task automatic tick();
    respond();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [2:0] cc,
                       input logic [DW-1:0] sd, input logic [2:0] rd,
                       input logic mr, input logic mw, input logic rw, input logic cw);
    ex_valid = v; ex_alu_result = alu; ex_ccr = cc; ex_store_data = sd; ex_rd = rd;
    ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_ccr_we = cw;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".wb_valid"}, wb_valid, 0);
    chk({tag, ".wb_rd"}, wb_rd, 0);
    chk({tag, ".wb_data"}, wb_data, 0);
    chk({tag, ".wb_reg_write"}, wb_reg_write, 0);
    chk({tag, ".ccr"}, ccr, 0);
    chk({tag, ".dmem_req"}, dmem_req, 0);
    chk({tag, ".dmem_we"}, dmem_we, 0);
    chk({tag, ".dmem_addr"}, dmem_addr, 0);
    chk({tag, ".dmem_wdata"}, dmem_wdata, 0);
    chk({tag, ".fwd_valid"}, fwd_valid, 0);
    chk({tag, ".ex_ready"}, ex_ready, 1);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; auto_ack = 0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    idle();
    model_reset();
    #2;
    reset_checks("por");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back ALU ops
    drive(1'b1, 16'h0005, 3'b000, '0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h8000, 3'b010, '0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("add1.wb_valid", wb_valid, 1);
    chk("add1.wb_data", wb_data, 16'h0005);
    idle();
    tick();
    chk("add2.wb_valid", wb_valid, 1);
    chk("add2.wb_data", wb_data, 16'h8000);
    chk("add2.ccr", ccr, 3'b010);

    // Load with two ack wait cycles, an ALU op waiting behind it
    drive(1'b1, 16'h0010, 3'b000, '0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h0044, 3'b000, '0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ld.req1", dmem_req, 1);
    tick();
    chk("ld.req2", dmem_req, 1);
    tick();
    chk("ld.req3", dmem_req, 1);
    chk("ld.ready_low", ex_ready, 0);
    dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 16'h0000;
    chk("ld.wb_data", wb_data, 16'hBEEF);
    chk("ld.wb_rd", wb_rd, 3'd3);
    chk("ld.req_fall", dmem_req, 0);
    tick();
    idle();
    tick();

    // Zero-wait store
    drive(1'b1, 16'h0020, 3'b000, 16'h1234, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    dmem_ack = 1'b1;
    chk("st.we", dmem_we, 1);
    chk("st.wdata", dmem_wdata, 16'h1234);
    tick();
    dmem_ack = 1'b0;
    chk("st.wb_valid", wb_valid, 1);
    chk("st.wb_reg_write", wb_reg_write, 0);

    // Flush while an ALU op is held
    drive(1'b1, 16'h0055, 3'b111, '0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("fl_alu.fwd_valid", fwd_valid, 1);
    chk("fl_alu.fwd_data", fwd_data, 16'h0055);
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_alu.wb_valid", wb_valid, 0);
    chk("fl_alu.ccr", ccr, 3'b010);

    // Flush while a load is outstanding
    drive(1'b1, 16'h0030, 3'b101, '0, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_mem.req_held", dmem_req, 1);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 16'h7777;
    tick();
    dmem_ack = 1'b0;
    chk("fl_mem.wb_valid", wb_valid, 0);
    chk("fl_mem.ccr", ccr, 3'b010);
    chk("fl_mem.req_fall", dmem_req, 0);

    // Read and write both set behaves as a store
    drive(1'b1, 16'h0040, 3'b000, 16'hABCD, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    dmem_ack = 1'b1;
    chk("rw.we", dmem_we, 1);
    tick();
    dmem_ack = 1'b0;
    chk("rw.wb_valid", wb_valid, 1);
    chk("rw.wb_reg_write", wb_reg_write, 0);
    chk("rw.wb_data", wb_data, 16'h0040);

    // Reset in the middle of an access
    drive(1'b1, 16'h0050, 3'b000, '0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    chk("rst_mid.req_before", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic with a random-latency memory
    auto_ack = 1;
    for (int i = 0; i < 500; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      drive(($urandom_range(0, 9) < 7), DW'($urandom), 3'($urandom), DW'($urandom),
            3'($urandom), (kind >= 5 && kind != 8), (kind >= 8),
            1'($urandom), 1'($urandom));
      flush = ($urandom_range(0, 11) == 0);
      tick();
    end
    idle();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
